// File: rtl/pipelined_tree_multiplier.sv
// Pipelined WIDTH x WIDTH multiplier: Baugh-Wooley partial products, a carry-save
// full-adder tree, and a Kogge-Stone prefix adder. Valid/ready at both ends.
module pipelined_tree_multiplier #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_x,
  input  logic [WIDTH-1:0]     in_y,
  input  logic                 in_signed,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_p,
  output logic [TAG_W-1:0]     out_tag
);

  localparam int P = 2 * WIDTH;

  // Rows left after one 3:2 level: each group of three becomes two, leftovers pass.
  function automatic int next_rows(input int n);
    return (n / 32'sd3) * 32'sd2 + (n % 32'sd3);
  endfunction

  function automatic int rows_at(input int lvl);
    int n;
    n = WIDTH + 32'sd1;
    for (int k = 32'sd0; k < lvl; k++) n = next_rows(n);
    return n;
  endfunction

  function automatic int num_levels();
    int n;
    int l;
    n = WIDTH + 32'sd1;
    l = 32'sd0;
    while (n > 32'sd2) begin
      n = next_rows(n);
      l++;
    end
    return l;
  endfunction

  localparam int NLVL = num_levels();

  // Baugh-Wooley constant: 2^WIDTH + 2^(2*WIDTH-1), added only in signed mode.
  localparam logic [P-1:0] BW_K = ({{(P-1){1'b0}}, 1'b1} << WIDTH) | {1'b1, {(P-1){1'b0}}};

  logic                 adv_s;
  logic [WIDTH-1:0]     tx_s;
  logic [WIDTH-1:0]     ty_s;
  logic                 tsg_s;
  logic                 tv_s;
  logic [TAG_W-1:0]     tt_s;
  logic [P-1:0]         sum_s;
  logic [P-1:0]         carry_s;
  logic [P-1:0]         aa_s;
  logic [P-1:0]         ab_s;
  logic                 av_s;
  logic [TAG_W-1:0]     at_s;
  logic [P-2:0]         gen_s;
  logic [P-2:0]         prop_s;
  logic [P-1:0]         prod_s;

  assign adv_s    = ~out_valid | out_ready;
  assign in_ready = adv_s;

  if (STAGES == 3) begin : g_op_rank
    logic [WIDTH-1:0] x_r;
    logic [WIDTH-1:0] y_r;
    logic             sg_r;
    logic             v_r;
    logic [TAG_W-1:0] tag_r;

    // Operand rank ahead of the reduction tree.
    always_ff @(posedge clk) begin
      if (rst) begin
        v_r   <= 1'b0;
        x_r   <= {WIDTH{1'b0}};
        y_r   <= {WIDTH{1'b0}};
        sg_r  <= 1'b0;
        tag_r <= {TAG_W{1'b0}};
      end else if (adv_s) begin
        v_r   <= in_valid;
        x_r   <= in_x;
        y_r   <= in_y;
        sg_r  <= in_signed;
        tag_r <= in_tag;
      end
    end

    assign tx_s  = x_r;
    assign ty_s  = y_r;
    assign tsg_s = sg_r;
    assign tv_s  = v_r;
    assign tt_s  = tag_r;
  end else begin : g_op_wire
    assign tx_s  = in_x;
    assign ty_s  = in_y;
    assign tsg_s = in_signed;
    assign tv_s  = in_valid;
    assign tt_s  = in_tag;
  end

  for (genvar l = 0; l <= NLVL; l++) begin : g_lvl
    localparam int N = rows_at(l);
    logic [P-1:0] rows [N];

    if (l == 0) begin : g_pp
      // Sign-row terms (exactly one index at WIDTH-1) are inverted in signed mode.
      for (genvar j = 0; j < WIDTH; j++) begin : g_row
        logic [WIDTH-1:0] inv_s;
        if (j == WIDTH - 1) begin : g_sgn
          assign inv_s = {1'b0, {(WIDTH-1){tsg_s}}};
        end else begin : g_mag
          assign inv_s = {tsg_s, {(WIDTH-1){1'b0}}};
        end
        assign rows[j] = {{WIDTH{1'b0}}, (tx_s & {WIDTH{ty_s[j]}}) ^ inv_s} << j;
      end
      assign rows[WIDTH] = tsg_s ? BW_K : {P{1'b0}};
    end else begin : g_red
      localparam int NP = rows_at(l - 1);
      localparam int NG = NP / 3;
      for (genvar g = 0; g < NG; g++) begin : g_fa
        logic [P-1:0] a_s;
        logic [P-1:0] b_s;
        logic [P-1:0] c_s;
        logic [P-1:0] maj_s;
        assign a_s   = g_lvl[l-1].rows[3*g];
        assign b_s   = g_lvl[l-1].rows[3*g+1];
        assign c_s   = g_lvl[l-1].rows[3*g+2];
        assign maj_s = (a_s & b_s) | (a_s & c_s) | (b_s & c_s);
        assign rows[2*g]   = a_s ^ b_s ^ c_s;
        assign rows[2*g+1] = {maj_s[P-2:0], 1'b0};
      end
      for (genvar k = 0; k < NP % 3; k++) begin : g_pass
        assign rows[2*NG+k] = g_lvl[l-1].rows[3*NG+k];
      end
    end
  end

  assign sum_s   = g_lvl[NLVL].rows[0];
  assign carry_s = g_lvl[NLVL].rows[1];

  if (STAGES >= 2) begin : g_cs_rank
    logic             v_r;
    logic [P-1:0]     sum_r;
    logic [P-1:0]     cry_r;
    logic [TAG_W-1:0] tag_r;

    // Carry-save rank between the tree and the prefix adder.
    always_ff @(posedge clk) begin
      if (rst) begin
        v_r   <= 1'b0;
        sum_r <= {P{1'b0}};
        cry_r <= {P{1'b0}};
        tag_r <= {TAG_W{1'b0}};
      end else if (adv_s) begin
        v_r   <= tv_s;
        sum_r <= sum_s;
        cry_r <= carry_s;
        tag_r <= tt_s;
      end
    end

    assign av_s = v_r;
    assign aa_s = sum_r;
    assign ab_s = cry_r;
    assign at_s = tag_r;
  end else begin : g_cs_wire
    assign av_s = tv_s;
    assign aa_s = sum_s;
    assign ab_s = carry_s;
    assign at_s = tt_s;
  end

  // Kogge-Stone carry tree; cells whose propagate is never consumed reduce to grey cells.
  always_comb begin
    gen_s  = aa_s[P-2:0] & ab_s[P-2:0];
    prop_s = aa_s[P-2:0] ^ ab_s[P-2:0];
    for (int d = 32'sd1; d < P - 1; d = d * 32'sd2) begin
      for (int i = P - 2; i >= d; i--) begin
        gen_s[i]  = gen_s[i] | (prop_s[i] & gen_s[i-d]);
        prop_s[i] = prop_s[i] & prop_s[i-d];
      end
    end
  end

  assign prod_s = aa_s ^ ab_s ^ {gen_s, 1'b0};

  // Output rank holds the result stable until the consumer takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_p     <= {P{1'b0}};
      out_tag   <= {TAG_W{1'b0}};
    end else if (adv_s) begin
      out_valid <= av_s;
      out_p     <= prod_s;
      out_tag   <= at_s;
    end
  end

endmodule
